// File: rtl/ipv4_cksum_pkg.sv
// Shared encodings, header offsets and the beat0 word-sum helper for the IPv4 checksum gate.
package ipv4_cksum_pkg;

  localparam int SUM_W  = 20;
  localparam int FOLD_W = 17;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

  localparam int ETYPE_LSB   = 144;
  localparam int VER_IHL_LSB = 136;
  localparam int B0_WORDS    = 9;
  localparam int B1_WORD_LSB = 240;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_B1 = 3'd1,
    ST_FOLD1   = 3'd2,
    ST_FOLD2   = 3'd3,
    ST_EMIT0   = 3'd4,
    ST_EMIT1   = 3'd5,
    ST_PASS    = 3'd6,
    ST_DROP    = 3'd7
  } state_t;

  // Nine header words of beat0 sit in [143:0], checksum field included.
  function automatic logic [SUM_W-1:0] sum_b0_words(input logic [B0_WORDS*16-1:0] d);
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < B0_WORDS; i++) s = s + SUM_W'(d[i*16 +: 16]);
    return s;
  endfunction

endpackage

// File: rtl/ones_comp_fold.sv
// One end-around-carry stage: low 16 bits plus whatever carries sit above them.
module ones_comp_fold
  import ipv4_cksum_pkg::*;
#(
  parameter int IN_W = SUM_W
) (
  input  logic [IN_W-1:0]   i_sum,
  output logic [FOLD_W-1:0] o_sum
);

  assign o_sum = FOLD_W'(i_sum[15:0]) + FOLD_W'(i_sum[IN_W-1:16]);

endmodule

// File: rtl/ipv4_cksum_ctrl.sv
// Holds the first two beats of a packet until the IPv4 header checksum is verified, then
// re-emits them tagged in TUSER and cuts through the rest. Optional CKSUM_DROP_BAD_EN drops bad packets.
//
// state    | meaning
// IDLE     | waiting for beat0, latch it and its 9-word sum
// WAIT_B1  | waiting for beat1, add its first header word
// FOLD1    | fold bits [19:16] into the low word
// FOLD2    | fold bit 16, produce verdict
// EMIT0    | drive held beat0 with verdict
// EMIT1    | drive held beat1
// PASS     | combinational cut-through until TLAST
// DROP     | swallow the rest of a bad packet
module ipv4_cksum_ctrl
  import ipv4_cksum_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CKSUM_CHK_POS        = 32,
  parameter int CKSUM_OK_POS         = 33
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  input  logic                              clear_counters,
  output logic [31:0]                       good_count,
  output logic [31:0]                       bad_count,
  output logic [31:0]                       bypass_count
);

  state_t                            r_state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    r_data0, r_data1;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  r_strb0, r_strb1;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   r_user0, r_user1;
  logic                              r_last0, r_last1;
  logic [SUM_W-1:0]                  r_sum;
  logic                              r_chk, r_ok;
  logic [31:0]                       r_good_cnt, r_bad_cnt, r_bypass_cnt;

  logic                              w_s_hs, w_emit0_hs, w_is_ipv4, w_fold_ok;
  logic                              w_inc_good, w_inc_bad, w_inc_bypass;
  logic [FOLD_W-1:0]                 w_fold1, w_fold2;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   w_user0_tag;

  ones_comp_fold #(.IN_W(SUM_W)) u_fold1 (
    .i_sum (r_sum),
    .o_sum (w_fold1)
  );

  ones_comp_fold #(.IN_W(FOLD_W)) u_fold2 (
    .i_sum (r_sum[FOLD_W-1:0]),
    .o_sum (w_fold2)
  );

  assign w_s_hs     = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_emit0_hs = (r_state == ST_EMIT0) && M_AXIS_TREADY;
  assign w_is_ipv4  = (S_AXIS_TDATA[ETYPE_LSB +: 16] == ETHERTYPE_IPV4) &&
                      (S_AXIS_TDATA[VER_IHL_LSB +: 8] == IPV4_VER_IHL);
  assign w_fold_ok  = (w_fold2 == FOLD_W'(17'h0FFFF));

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_state <= ST_IDLE;
      r_data0 <= '0;
      r_strb0 <= '0;
      r_user0 <= '0;
      r_last0 <= 1'b0;
      r_data1 <= '0;
      r_strb1 <= '0;
      r_user1 <= '0;
      r_last1 <= 1'b0;
      r_sum   <= '0;
      r_chk   <= 1'b0;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_s_hs) begin
          r_data0 <= S_AXIS_TDATA;
          r_strb0 <= S_AXIS_TSTRB;
          r_user0 <= S_AXIS_TUSER;
          r_last0 <= S_AXIS_TLAST;
          r_sum   <= sum_b0_words(S_AXIS_TDATA[B0_WORDS*16-1:0]);
          r_ok    <= 1'b0;
          if (w_is_ipv4 && !S_AXIS_TLAST) begin
            r_chk   <= 1'b1;
            r_state <= ST_WAIT_B1;
          end else begin
            r_chk   <= 1'b0;
            r_state <= ST_EMIT0;
          end
        end
        ST_WAIT_B1: if (w_s_hs) begin
          r_data1 <= S_AXIS_TDATA;
          r_strb1 <= S_AXIS_TSTRB;
          r_user1 <= S_AXIS_TUSER;
          r_last1 <= S_AXIS_TLAST;
          r_sum   <= r_sum + SUM_W'(S_AXIS_TDATA[B1_WORD_LSB +: 16]);
          r_state <= ST_FOLD1;
        end
        ST_FOLD1: begin
          r_sum   <= SUM_W'(w_fold1);
          r_state <= ST_FOLD2;
        end
        ST_FOLD2: begin
          r_sum <= SUM_W'(w_fold2);
          r_ok  <= w_fold_ok;
`ifdef CKSUM_DROP_BAD_EN
          if (!w_fold_ok) r_state <= r_last1 ? ST_IDLE : ST_DROP;
          else            r_state <= ST_EMIT0;
`else
          r_state <= ST_EMIT0;
`endif
        end
        ST_EMIT0: if (M_AXIS_TREADY) begin
          if (r_chk)        r_state <= ST_EMIT1;
          else if (r_last0) r_state <= ST_IDLE;
          else              r_state <= ST_PASS;
        end
        ST_EMIT1: if (M_AXIS_TREADY) r_state <= r_last1 ? ST_IDLE : ST_PASS;
        ST_PASS, ST_DROP: if (w_s_hs && S_AXIS_TLAST) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_user0_tag                = r_user0;
    w_user0_tag[CKSUM_CHK_POS] = r_chk;
    w_user0_tag[CKSUM_OK_POS]  = r_ok;
  end

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = r_data0;
    M_AXIS_TSTRB  = r_strb0;
    M_AXIS_TUSER  = w_user0_tag;
    M_AXIS_TLAST  = r_last0;
    case (r_state)
      ST_IDLE, ST_WAIT_B1, ST_DROP: S_AXIS_TREADY = 1'b1;
      ST_EMIT0: M_AXIS_TVALID = 1'b1;
      ST_EMIT1: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = r_data1;
        M_AXIS_TSTRB  = r_strb1;
        M_AXIS_TUSER  = r_user1;
        M_AXIS_TLAST  = r_last1;
      end
      ST_PASS: begin
        S_AXIS_TREADY = M_AXIS_TREADY;
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TSTRB  = S_AXIS_TSTRB;
        M_AXIS_TUSER  = S_AXIS_TUSER;
        M_AXIS_TLAST  = S_AXIS_TLAST;
      end
      default: ;
    endcase
  end

  // A dropped packet never reaches EMIT0, so its bad count is taken at the verdict.
  assign w_inc_good   = w_emit0_hs && r_chk && r_ok;
  assign w_inc_bypass = w_emit0_hs && !r_chk;
`ifdef CKSUM_DROP_BAD_EN
  assign w_inc_bad    = (w_emit0_hs && r_chk && !r_ok) || ((r_state == ST_FOLD2) && !w_fold_ok);
`else
  assign w_inc_bad    = w_emit0_hs && r_chk && !r_ok;
`endif

  always_ff @(posedge AXI_ACLK or posedge AXI_RESET) begin
    if (AXI_RESET) begin
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_bypass_cnt <= '0;
    end else if (clear_counters) begin
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_bypass_cnt <= '0;
    end else begin
      if (w_inc_good)   r_good_cnt   <= r_good_cnt + 32'd1;
      if (w_inc_bad)    r_bad_cnt    <= r_bad_cnt + 32'd1;
      if (w_inc_bypass) r_bypass_cnt <= r_bypass_cnt + 32'd1;
    end
  end

  assign good_count   = r_good_cnt;
  assign bad_count    = r_bad_cnt;
  assign bypass_count = r_bypass_cnt;

endmodule

// File: tb/tb_ipv4_cksum_ctrl.sv
// Directed bench for ipv4_cksum_ctrl using a hand-checked IPv4 header (checksum 16'hB861).
module tb_ipv4_cksum_ctrl;

  localparam logic [255:0] B0_GOOD = {96'hA1A2A3A4A5A6B1B2B3B4B5B6, 16'h0800,
    16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hB861, 16'hC0A8, 16'h0001, 16'hC0A8};
  localparam logic [255:0] B0_BAD = {96'hA1A2A3A4A5A6B1B2B3B4B5B6, 16'h0800,
    16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011, 16'hB860, 16'hC0A8, 16'h0001, 16'hC0A8};
  localparam logic [255:0] B1   = {16'h00C7, {15{16'h1111}}};
  localparam logic [255:0] B2   = {16{16'h2222}};
  localparam logic [255:0] B3   = {16{16'h3333}};
  localparam logic [255:0] ARP0 = {96'hFFFFFFFFFFFF020000000001, 16'h0806, {9{16'h0001}}};
  localparam logic [127:0] U0   = 128'h0123_4567_89AB_CDEF_0000_0000_5A5A_5A5A;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] s_tdata = '0;
  logic [31:0]  s_tstrb = '1;
  logic [127:0] s_tuser = '0;
  logic         s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid, m_tlast;
  logic         m_tready = 1'b1;
  logic         clear_counters = 1'b0;
  logic [31:0]  good_count, bad_count, bypass_count;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, s_hs_cnt = 0, s_hs_cyc = 0;

  typedef struct {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
    int           c;
  } beat_t;
  beat_t mq[$];

  ipv4_cksum_ctrl dut (
    .AXI_ACLK       (clk),
    .AXI_RESET      (rst),
    .S_AXIS_TDATA   (s_tdata),
    .S_AXIS_TSTRB   (s_tstrb),
    .S_AXIS_TUSER   (s_tuser),
    .S_AXIS_TVALID  (s_tvalid),
    .S_AXIS_TLAST   (s_tlast),
    .S_AXIS_TREADY  (s_tready),
    .M_AXIS_TDATA   (m_tdata),
    .M_AXIS_TSTRB   (m_tstrb),
    .M_AXIS_TUSER   (m_tuser),
    .M_AXIS_TVALID  (m_tvalid),
    .M_AXIS_TLAST   (m_tlast),
    .M_AXIS_TREADY  (m_tready),
    .clear_counters (clear_counters),
    .good_count     (good_count),
    .bad_count      (bad_count),
    .bypass_count   (bypass_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs only change just after a rising edge, so a negedge sample sees the coming handshake.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) mq.push_back('{m_tdata, m_tstrb, m_tuser, m_tlast, cyc});
    if (!rst && s_tvalid && s_tready) s_hs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] tag_user(input logic [127:0] u, input logic [1:0] v);
    logic [127:0] r;
    r = u;
    r[33:32] = v;
    return r;
  endfunction

  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
    int n;
    @(posedge clk); #1;
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check_eq("s_ready_timeout", s_tready, 1'b1);
    s_hs_cyc = cyc;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    for (int i = 0; i < 200 && mq.size() < n; i++) @(negedge clk);
    repeat (6) @(negedge clk);
    check_eq({tag, "_count"}, mq.size(), n);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [255:0] d,
                          input logic [127:0] u, input logic l);
    if (idx < mq.size()) begin
      check_eq({tag, "_data"}, mq[idx].d, d);
      check_eq({tag, "_strb"}, mq[idx].s, 32'hFFFF_FFFF);
      check_eq({tag, "_user"}, mq[idx].u, u);
      check_eq({tag, "_last"}, mq[idx].l, l);
    end else begin
      check_eq({tag, "_missing"}, mq.size(), idx + 1);
    end
  endtask

  task automatic wait_m_valid(input string tag);
    for (int i = 0; i < 50 && !m_tvalid; i++) @(negedge clk);
    check_eq(tag, m_tvalid, 1'b1);
  endtask

  initial begin
    int ref_cyc, base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_m_valid", m_tvalid, 1'b0);
    check_eq("rst_s_ready", s_tready, 1'b1);
    check_eq("rst_good", good_count, 0);
    check_eq("rst_bad", bad_count, 0);
    check_eq("rst_bypass", bypass_count, 0);

    // good 3-beat IPv4 packet
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b0);
    ref_cyc = s_hs_cyc;
    send_beat(B2, U0, 1'b1);
    wait_out("t1", 3);
    chk_beat("t1_b0", 0, B0_GOOD, tag_user(U0, 2'b11), 1'b0);
    chk_beat("t1_b1", 1, B1, U0, 1'b0);
    chk_beat("t1_b2", 2, B2, U0, 1'b1);
    if (mq.size() > 0) check_eq("t1_latency", mq[0].c - ref_cyc, 3);
    check_eq("t1_good", good_count, 1);
    mq.delete();

    // bad checksum
    base = s_hs_cnt;
    send_beat(B0_BAD, U0, 1'b0);
    send_beat(B1, U0, 1'b0);
    send_beat(B2, U0, 1'b1);
`ifdef CKSUM_DROP_BAD_EN
    wait_out("t2_drop", 0);
    check_eq("t2_s_drained", s_hs_cnt - base, 3);
`else
    wait_out("t2", 3);
    chk_beat("t2_b0", 0, B0_BAD, tag_user(U0, 2'b01), 1'b0);
    chk_beat("t2_b1", 1, B1, U0, 1'b0);
    chk_beat("t2_b2", 2, B2, U0, 1'b1);
`endif
    check_eq("t2_bad", bad_count, 1);
    check_eq("t2_good", good_count, 1);
    mq.delete();

    // ARP frame, then a 1-beat IPv4 packet: both bypass
    send_beat(ARP0, U0, 1'b0);
    ref_cyc = s_hs_cyc;
    send_beat(B3, U0, 1'b1);
    send_beat(B0_GOOD, U0, 1'b1);
    wait_out("t3", 3);
    chk_beat("t3_arp0", 0, ARP0, tag_user(U0, 2'b00), 1'b0);
    chk_beat("t3_arp1", 1, B3, U0, 1'b1);
    chk_beat("t3_short", 2, B0_GOOD, tag_user(U0, 2'b00), 1'b1);
    if (mq.size() > 0) check_eq("t3_latency", mq[0].c - ref_cyc, 1);
    check_eq("t3_bypass", bypass_count, 2);
    mq.delete();

    // egress stall during EMIT0
    @(posedge clk); #1;
    m_tready = 1'b0;
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b0);
    wait_m_valid("t4_emit0_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("t4_stall_valid", m_tvalid, 1'b1);
      check_eq("t4_stall_data", m_tdata, B0_GOOD);
      check_eq("t4_stall_user", m_tuser, tag_user(U0, 2'b11));
      check_eq("t4_stall_s_ready", s_tready, 1'b0);
    end
    @(posedge clk); #1;
    m_tready = 1'b1;
    send_beat(B2, U0, 1'b1);
    wait_out("t4", 3);
    chk_beat("t4_b0", 0, B0_GOOD, tag_user(U0, 2'b11), 1'b0);
    chk_beat("t4_b1", 1, B1, U0, 1'b0);
    chk_beat("t4_b2", 2, B2, U0, 1'b1);
    check_eq("t4_good", good_count, 2);
    mq.delete();

    // reset while cutting through
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b0);
    wait_out("t5_head", 2);
    @(posedge clk); #1;
    s_tdata = B2; s_tuser = U0; s_tlast = 1'b0; s_tvalid = 1'b1;
    #1;
    check_eq("t5_pass_valid", m_tvalid, 1'b1);
    check_eq("t5_pass_data", m_tdata, B2);
    rst = 1'b1;
    #1;
    check_eq("t5_rst_valid", m_tvalid, 1'b0);
    check_eq("t5_rst_good", good_count, 0);
    check_eq("t5_rst_bad", bad_count, 0);
    check_eq("t5_rst_bypass", bypass_count, 0);
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b1);
    wait_out("t5_after", 2);
    chk_beat("t5_b0", 0, B0_GOOD, tag_user(U0, 2'b11), 1'b0);
    chk_beat("t5_b1", 1, B1, U0, 1'b1);
    check_eq("t5_good", good_count, 1);
    mq.delete();

    // good_count wrap
    @(posedge clk); #1;
    force dut.r_good_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_good_cnt;
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b1);
    wait_out("t6_wrap", 2);
    check_eq("t6_wrap_good", good_count, 0);
    send_beat(ARP0, U0, 1'b1);
    wait_out("t6_arp", 3);
    check_eq("t6_bypass", bypass_count, 1);
    mq.delete();

    // clear in the same cycle as a good increment
    @(posedge clk); #1;
    m_tready = 1'b0;
    send_beat(B0_GOOD, U0, 1'b0);
    send_beat(B1, U0, 1'b1);
    wait_m_valid("t6_emit0_valid");
    @(posedge clk); #1;
    m_tready = 1'b1;
    clear_counters = 1'b1;
    @(posedge clk); #1;
    clear_counters = 1'b0;
    wait_out("t6_clr", 2);
    chk_beat("t6_clr_b0", 0, B0_GOOD, tag_user(U0, 2'b11), 1'b0);
    check_eq("t6_clr_good", good_count, 0);
    check_eq("t6_clr_bypass", bypass_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
